// File: rtl/centroid_tracker.sv
// centroid_tracker: classifies RGB pixels against NUM_CH colour boxes, accumulates
// per-channel count and coordinate sums per frame, and emits serially divided centroids.
module centroid_tracker #(
   parameter int NUM_CH     = 2,
   parameter int DATA_W     = 12,
   parameter int COORD_W    = 11,
   parameter int FRAME_W    = 640,
   parameter int FRAME_H    = 480,
   parameter int MIN_PIXELS = 16
) (
   input  logic                                    iCLK,
   input  logic                                    iRST,
   input  logic                                    iDVAL,
   input  logic [DATA_W-1:0]                       iRed,
   input  logic [DATA_W-1:0]                       iGreen,
   input  logic [DATA_W-1:0]                       iBlue,
   input  logic [COORD_W-1:0]                      iX_Cont,
   input  logic [COORD_W-1:0]                      iY_Cont,
   input  logic [NUM_CH*3*DATA_W-1:0]              iLo,
   input  logic [NUM_CH*3*DATA_W-1:0]              iHi,
   input  logic                                    iREADY,
   output logic                                    oDVAL,
   output logic [((NUM_CH>1)?$clog2(NUM_CH):1)-1:0] oCh,
   output logic [COORD_W-1:0]                      oX,
   output logic [COORD_W-1:0]                      oY,
   output logic                                    oFound,
   output logic                                    oOverrun
);
   localparam int CNT_W = $clog2(FRAME_W*FRAME_H+1);
   localparam int SUM_W = CNT_W+COORD_W;
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CFG_W = 3*DATA_W;
   localparam int DC_W  = $clog2(SUM_W+1);

   typedef enum logic [1:0] {IDLE, LOAD, DIV, EMIT} state_t;

   logic [NUM_CH*CFG_W-1:0] lo_q, hi_q, lo_c, hi_c;
   logic                    sof;
   logic [NUM_CH-1:0]       match, s1_match;
   logic [COORD_W-1:0]      s1_x, s1_y;
   logic                    s1_eof;
   logic [CNT_W-1:0]        acc_cnt [NUM_CH];
   logic [SUM_W-1:0]        acc_sx [NUM_CH];
   logic [SUM_W-1:0]        acc_sy [NUM_CH];
   logic [CNT_W-1:0]        nxt_cnt [NUM_CH];
   logic [SUM_W-1:0]        nxt_sx [NUM_CH];
   logic [SUM_W-1:0]        nxt_sy [NUM_CH];
   logic [CNT_W-1:0]        res_cnt [NUM_CH];
   logic [SUM_W-1:0]        res_sx [NUM_CH];
   logic [SUM_W-1:0]        res_sy [NUM_CH];
   state_t                  state;
   logic [CH_W-1:0]         ch;
   logic [DC_W-1:0]         step;
   logic [CNT_W-1:0]        dvsr, rx, ry;
   logic [SUM_W-1:0]        qx, qy;
   logic [CNT_W:0]          shx, shy;
   logic                    gex, gey;

   // The first pixel of a frame already classifies against the config it latches.
   assign sof  = iDVAL && iX_Cont == '0 && iY_Cont == '0;
   assign lo_c = sof ? iLo : lo_q;
   assign hi_c = sof ? iHi : hi_q;

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         lo_q <= '0;
         hi_q <= '0;
      end else if (sof) begin
         lo_q <= iLo;
         hi_q <= iHi;
      end
   end

   always_comb begin
      match = '0;
      for (int c = 0; c < NUM_CH; c++)
         match[c] = iDVAL
            && iRed   >= lo_c[c*CFG_W+2*DATA_W +: DATA_W] && iRed   <= hi_c[c*CFG_W+2*DATA_W +: DATA_W]
            && iGreen >= lo_c[c*CFG_W+DATA_W   +: DATA_W] && iGreen <= hi_c[c*CFG_W+DATA_W   +: DATA_W]
            && iBlue  >= lo_c[c*CFG_W          +: DATA_W] && iBlue  <= hi_c[c*CFG_W          +: DATA_W];
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         s1_match <= '0;
         s1_x     <= '0;
         s1_y     <= '0;
         s1_eof   <= 1'b0;
      end else begin
         s1_match <= match;
         s1_x     <= iX_Cont;
         s1_y     <= iY_Cont;
         s1_eof   <= iDVAL && iX_Cont == COORD_W'(FRAME_W-1) && iY_Cont == COORD_W'(FRAME_H-1);
      end
   end

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         nxt_cnt[c] = acc_cnt[c] + CNT_W'(s1_match[c]);
         nxt_sx[c]  = acc_sx[c] + (s1_match[c] ? SUM_W'(s1_x) : '0);
         nxt_sy[c]  = acc_sy[c] + (s1_match[c] ? SUM_W'(s1_y) : '0);
      end
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         for (int c = 0; c < NUM_CH; c++) begin
            acc_cnt[c] <= '0;
            acc_sx[c]  <= '0;
            acc_sy[c]  <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            acc_cnt[c] <= s1_eof ? '0 : nxt_cnt[c];
            acc_sx[c]  <= s1_eof ? '0 : nxt_sx[c];
            acc_sy[c]  <= s1_eof ? '0 : nxt_sy[c];
         end
      end
   end

   // Restoring division step shared divisor; remainder stays below the divisor.
   assign shx = {rx, qx[SUM_W-1]};
   assign shy = {ry, qy[SUM_W-1]};
   assign gex = shx >= {1'b0, dvsr};
   assign gey = shy >= {1'b0, dvsr};

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         state    <= IDLE;
         ch       <= '0;
         step     <= '0;
         dvsr     <= '0;
         rx       <= '0;
         ry       <= '0;
         qx       <= '0;
         qy       <= '0;
         oDVAL    <= 1'b0;
         oCh      <= '0;
         oX       <= '0;
         oY       <= '0;
         oFound   <= 1'b0;
         oOverrun <= 1'b0;
         for (int c = 0; c < NUM_CH; c++) begin
            res_cnt[c] <= '0;
            res_sx[c]  <= '0;
            res_sy[c]  <= '0;
         end
      end else begin
         oOverrun <= s1_eof && state != IDLE;
         if (s1_eof && state == IDLE)
            for (int c = 0; c < NUM_CH; c++) begin
               res_cnt[c] <= nxt_cnt[c];
               res_sx[c]  <= nxt_sx[c];
               res_sy[c]  <= nxt_sy[c];
            end
         case (state)
            IDLE: if (s1_eof) begin
               state <= LOAD;
               ch    <= '0;
            end
            LOAD: begin
               dvsr  <= res_cnt[ch];
               qx    <= res_sx[ch];
               qy    <= res_sy[ch];
               rx    <= '0;
               ry    <= '0;
               step  <= '0;
               state <= DIV;
            end
            DIV: if (step == DC_W'(SUM_W)) begin
               oDVAL  <= 1'b1;
               oCh    <= ch;
               oX     <= dvsr == '0 ? '0 : qx[COORD_W-1:0];
               oY     <= dvsr == '0 ? '0 : qy[COORD_W-1:0];
               oFound <= dvsr != '0 && dvsr >= CNT_W'(MIN_PIXELS);
               state  <= EMIT;
            end else begin
               rx   <= gex ? CNT_W'(shx - {1'b0, dvsr}) : shx[CNT_W-1:0];
               ry   <= gey ? CNT_W'(shy - {1'b0, dvsr}) : shy[CNT_W-1:0];
               qx   <= {qx[SUM_W-2:0], gex};
               qy   <= {qy[SUM_W-2:0], gey};
               step <= step + 1'b1;
            end
            EMIT: if (iREADY) begin
               oDVAL <= 1'b0;
               state <= ch == CH_W'(NUM_CH-1) ? IDLE : LOAD;
               ch    <= ch == CH_W'(NUM_CH-1) ? '0 : ch + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
